// File: rtl/right_shift_multiplier_pkg.sv
// Shared constants and types for the radix-2 Booth right-shift multiplier.
package right_shift_multiplier_pkg;

    localparam int RSM_WIDTH = 32;

    function automatic int rsm_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int RSM_CNT_W = rsm_cnt_width(RSM_WIDTH);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } rsm_state_e;

endpackage

// File: rtl/right_shift_multiplier_if.sv
// Operand/product bundle for right_shift_multiplier; done exists only with RSM_DONE_EN.
// Operands are held stable by the master from reset release until completion.
interface right_shift_multiplier_if #(
    parameter int WIDTH = 32
);
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   x;
    logic signed [2*WIDTH-1:0] p;
`ifdef RSM_DONE_EN
    logic                      done;

    modport master (output a, output x, input p, input done);
    modport slave  (input a, input x, output p, output done);
`else
    modport master (output a, output x, input p);
    modport slave  (input a, input x, output p);
`endif
endinterface

// File: rtl/right_shift_multiplier_booth_step.sv
// One radix-2 Booth iteration: signed add/sub of a into the upper half, then an
// arithmetic right shift of the whole accumulator.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic               x_bit_i,
    input  logic               q_prev_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic signed [WIDTH:0]   upper_ext;
    logic signed [WIDTH:0]   a_ext;
    logic signed [WIDTH:0]   sum;
    logic signed [2*WIDTH:0] wide;

    // One guard bit keeps the sign correct when a is the most-negative value.
    assign upper_ext = {acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]};
    assign a_ext     = {a_i[WIDTH-1], a_i};

    always_comb begin
        sum = upper_ext;
        case ({x_bit_i, q_prev_i})
            2'b10:   sum = upper_ext - a_ext;
            2'b01:   sum = upper_ext + a_ext;
            default: sum = upper_ext;
        endcase
    end

    assign wide  = {sum, acc_i[WIDTH-1:0]};
    assign acc_o = (2*WIDTH)'(wide >>> 1);

endmodule

// File: rtl/right_shift_multiplier.sv
// Iterative signed Booth multiplier: WIDTH cycles after reset release p = a*x.
// Optional done output compiled in with RSM_DONE_EN.
module right_shift_multiplier
    import right_shift_multiplier_pkg::*;
#(
    parameter int WIDTH = RSM_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    right_shift_multiplier_if.slave  bus,
    output rsm_state_e               state_o
);

    localparam int CNT_W = rsm_cnt_width(WIDTH);
    localparam int IDX_W = $clog2(WIDTH);

    rsm_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               q_prev_q, q_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               step_en;
    logic               last_step;
    logic [IDX_W-1:0]   bit_idx;
    logic [2*WIDTH-1:0] acc_step;

    assign bit_idx   = cnt_q[IDX_W-1:0];
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .acc_i    (acc_q),
        .a_i      (bus.a),
        .x_bit_i  (bus.x[bit_idx]),
        .q_prev_i (q_prev_q),
        .acc_o    (acc_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            acc_q    <= '0;
            q_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_prev_q <= q_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        step_en = (state_q == RUN);
    end

    // DONE freezes the datapath so p holds until the next reset.
    always_comb begin
        acc_d    = acc_q;
        q_prev_d = q_prev_q;
        cnt_d    = cnt_q;
        if (step_en) begin
            acc_d    = acc_step;
            q_prev_d = bus.x[bit_idx];
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    assign bus.p   = acc_q;
    assign state_o = state_q;

`ifdef RSM_DONE_EN
    assign bus.done = (state_q == DONE);
`endif

endmodule

// File: tb/tb_right_shift_multiplier.sv
// Directed bench for right_shift_multiplier: hand-computed products, reset and
// hold behaviour, mid-run reset, and a corner-value cross product.
module tb_right_shift_multiplier;
  import right_shift_multiplier_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  rsm_state_e state_dbg;
  int n_tests;
  int n_fail;
  logic [2*W-1:0] exp_q[$];

  right_shift_multiplier_if #(.WIDTH(W)) bus ();

  right_shift_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef RSM_DONE_EN
    check(tag, {{(2*W-1){1'b0}}, bus.done}, {{(2*W-1){1'b0}}, exp});
`else
    check(tag, {{(2*W-1){1'b0}}, state_dbg == DONE}, {{(2*W-1){1'b0}}, exp});
`endif
  endtask

  // Hold reset, load operands, release away from the rising edge.
  task automatic start_run(input logic [W-1:0] av, input logic [W-1:0] xv);
    @(negedge clk);
    rst = 1'b0;
    bus.a = av;
    bus.x = xv;
    #2;
    rst = 1'b1;
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] xv,
                         input logic [2*W-1:0] exp);
    exp_q.push_back(exp);
    start_run(av, xv);
    repeat (W - 1) @(posedge clk);
    @(negedge clk);
    check_done({tag, "_done_early"}, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check(tag, bus.p, exp_q.pop_front());
    check_done({tag, "_done"}, 1'b1);
  endtask

  initial begin
    logic [W-1:0] corners[5];
    logic [2*W-1:0] held;
    longint ea;
    longint ex;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.a = '0;
    bus.x = '0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h8000_0000;

    repeat (3) @(negedge clk);
    check("reset_p", bus.p, '0);
    check_done("reset_done", 1'b0);

    run_mul("sq", 32'h1234_5678, 32'h1234_5678, 64'd93281312872650816);
    run_mul("max_x2", 32'h7FFF_FFFF, 32'd2, 64'd4294967294);
    run_mul("min_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 64'd2147483648);
    run_mul("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("p2_m3", 32'd2, -32'sd3, -64'sd6);
    run_mul("m2_p3", -32'sd2, 32'd3, -64'sd6);
    run_mul("p1_neg", 32'd1, -32'sh7654_3210, -64'sd1985229328);

    // Zero product: p stays 0 during reset and holds after completion.
    @(negedge clk);
    rst = 1'b0;
    bus.a = 32'd0;
    bus.x = 32'h12;
    repeat (2) @(negedge clk);
    check("zero_in_reset", bus.p, '0);
    run_mul("zero", 32'd0, 32'h12, 64'd0);

    run_mul("hold", 32'h1234_5678, 32'hFFFF_FFF0, -64'sd4886718336);
    held = bus.p;
    repeat (10) @(negedge clk);
    check("hold_p", bus.p, -64'sd4886718336);
    check("hold_stable", bus.p, held);
    check_done("hold_done", 1'b1);

    // Mid-run reset clears asynchronously; the restart then completes exactly.
    start_run(32'h7654_3210, 32'h1234_5678);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_p", bus.p, '0);
    check_done("midrst_done", 1'b0);
    run_mul("midrst_rerun", 32'h7654_3210, 32'h1234_5678, 64'd606328534893909888);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        ea = longint'($signed(corners[i]));
        ex = longint'($signed(corners[j]));
        run_mul($sformatf("corner_%0d_%0d", i, j), corners[i], corners[j], 64'(ea * ex));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/right_shift_multiplier.md
# right_shift_multiplier

Sequential signed multiplier using radix-2 Booth recoding with a right-shifting accumulator. It forms the full-precision two's-complement product of two WIDTH-bit operands in exactly WIDTH clock cycles after reset release. It serves as a low-area iterative multiply unit. Each new multiply is started by pulsing reset; there is no start strobe.

## Interface
- WIDTH, default 32: operand width. The product is 2*WIDTH bits.
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous, active-low reset. It clears all state. Releasing it starts a multiply.
- a  input  WIDTH: signed multiplicand.
- x  input  WIDTH: signed multiplier.
- p  output  2*WIDTH: signed product register.
- done  output  1: present only with RSM_DONE_EN. High when p holds the final product.

## Operation
- Operand handling:
  - a and x are read combinationally every cycle.
  - Both must be held stable from reset release until completion.
  - If either changes during the run, the result is undefined.
- Registers:
  - acc: 2*WIDTH bits, drives p directly.
  - q_prev: 1-bit Booth history.
  - cnt: a counter sized to reach WIDTH.
  - state: RUN or DONE.
- Step i (i = cnt, from 0 to WIDTH-1). The Booth pair is {x[i], q_prev}:
  - 10: subtract a from the upper half.
  - 01: add a to the upper half.
  - 00 or 11: no operation.
- Datapath for each step:
  - The add/subtract is done at WIDTH+1 bits. Both acc's upper WIDTH bits and a are sign-extended by one bit.
  - The result is then arithmetically shifted right by one and combined with the lower half. This keeps the sign bit correct when a = most-negative value.
  - After the step: q_prev <= x[i], cnt <= cnt+1.
- Step 0 uses acc = 0 and q_prev = 0.
- State transitions:
  - RUN moves to DONE on the step with cnt == WIDTH-1.
  - DONE is terminal. acc and cnt hold, and p stays constant until the next reset.
- Result width: p is exact for all operand pairs. The product of two most-negative values, and the product of the most-negative value with -1 (result 2^(2*WIDTH-2) or 2^(WIDTH-1)), both fit without overflow.

## Timing
- While rst is low: p = 0, cnt = 0, q_prev = 0, state = RUN, done = 0.
- The first rising edge with rst high performs step 0.
- After WIDTH rising edges (32 at default, 320 ns at 100 MHz), p equals a*x. done rises on that same edge.
- Intermediate p values are partial sums. They are visible but not meaningful.
- Reset asserted mid-run: all state clears immediately and asynchronously. Releasing reset restarts from step 0.
- Reset released coincident with a clock edge: the release is treated as taking effect before that edge. Benches must not release reset within hold time of the edge.

## Configuration
- RSM_DONE_EN defined: the done port and its state-derived logic are compiled in.
- RSM_DONE_EN undefined: there is no done port. Completion is inferred from the fixed WIDTH-cycle latency, and the multiply result is identical.

## Structure
- Package right_shift_multiplier_pkg holds:
  - the default WIDTH constant (32)
  - the counter width constant, $clog2(WIDTH)+1
  - the state enum typedef (RUN, DONE)
- Sub-module booth_step: purely combinational. Inputs are acc, a, x[i] and q_prev; output is the next acc. It implements the sign-extended add/sub and the arithmetic shift.
- The top-level holds the registers, counter and state machine.

## Test plan
- a=0x12345678, x=0x12345678, run 32 cycles -> p=93281312872650816, done=1.
- a=0x7FFFFFFF, x=2 -> p=4294967294. a=0x80000000, x=-1 -> p=2147483648, with no sign corruption.
- Mixed signs:
  - a=2, x=-3 -> p=-6.
  - a=-2, x=3 -> p=-6.
  - a=1, x=-0x76543210 -> p=-1985229328.
- a=0, x=0x12 -> p=0. Check that p stays 0 during reset and holds unchanged for 10 extra cycles after done.
- Assert rst low at cycle 15 of a run with a=0x76543210, x=0x12345678 -> p and done clear immediately. After release and 32 cycles -> p=a*x exactly.
- Randomized: 1000 signed operand pairs, including corner values 0, 1, -1, 0x7FFFFFFF and 0x80000000. p must match the 64-bit reference product after each 32-cycle run.
